// File: rtl/occupancy_tracker_pkg.sv
// -----------------------------------------------------------------------------
// occupancy_tracker_pkg
// Shared definitions for the occupancy tracker:
//   - drain_state_e      : drain sequencer states (IDLE, DRAIN, DONE)
//   - ch_lsb()           : lowest bit index of channel ch inside a packed
//                          per-channel vector (slice is [ch_lsb +: cnt_w])
//   - max_outstanding_ok : elaboration-time check that the occupancy limit
//                          is non-zero and fits in the counter width
// -----------------------------------------------------------------------------
package occupancy_tracker_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } drain_state_e;

   // Start bit of channel ch in a vector holding one cnt_w-bit field per channel.
   function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned cnt_w);
      return ch * cnt_w;
   endfunction

   // True when 1 <= max_out <= 2**cnt_w - 1.
   function automatic bit max_outstanding_ok(input longint unsigned max_out,
                                             input int unsigned     cnt_w);
      longint unsigned limit;
      limit = (64'd1 << cnt_w) - 64'd1;
      return (max_out >= 64'd1) && (max_out <= limit);
   endfunction

endpackage

// File: rtl/occupancy_counter.sv
// -----------------------------------------------------------------------------
// occupancy_counter
// One channel of the tracker: saturating in-flight counter with registered
// busy flag and sticky overflow/underflow flags.
//
// Ports:
//   aclk, reset     clock, synchronous active-high reset
//   sig_in          one value enters this cycle
//   sig_out         one value leaves this cycle
//   err_clr         clear sticky error flags (a new error in the same cycle wins)
//   draining        drain in progress; blocks can_accept
//   can_accept      channel may take a value (from registered state only)
//   busy            registered (count != 0)
//   count           current occupancy
//   count_next      next-cycle occupancy (used by drain FSM / high-water)
//   err_overflow    sticky: increment attempted at the limit
//   err_underflow   sticky: decrement attempted at zero
// -----------------------------------------------------------------------------
module occupancy_counter
   import occupancy_tracker_pkg::*;
#(
   parameter int unsigned CNT_W           = 8,
   parameter int unsigned MAX_OUTSTANDING = 255
) (
   input  logic             aclk,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             sig_out,
   input  logic             err_clr,
   input  logic             draining,
   output logic             can_accept,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next,
   output logic             err_overflow,
   output logic             err_underflow
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO    = '0;

   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q;
   logic             err_ovf_q, err_ovf_d;
   logic             err_unf_q, err_unf_d;
   logic             inc_s, dec_s, ovf_s, unf_s;

   // Next count with saturation at both ends; errors are raised instead of wrapping.
   always_comb begin
      inc_s = sig_in & ~sig_out;
      dec_s = sig_out & ~sig_in;
      ovf_s = inc_s & (count_q == MAX_CNT);
      unf_s = dec_s & (count_q == ZERO);
      count_d = count_q;
      if (inc_s && !ovf_s) begin
         count_d = count_q + ONE;
      end else if (dec_s && !unf_s) begin
         count_d = count_q - ONE;
      end else begin
         count_d = count_q;
      end
      // A fresh error has priority over a clear in the same cycle.
      err_ovf_d = ovf_s | (err_ovf_q & ~err_clr);
      err_unf_d = unf_s | (err_unf_q & ~err_clr);
   end

   // Counter, busy and sticky error registers.
   always_ff @(posedge aclk) begin
      if (reset) begin
         count_q   <= ZERO;
         busy_q    <= 1'b0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         busy_q    <= (count_d != ZERO);
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

   assign can_accept    = (count_q < MAX_CNT) & ~draining;
   assign busy          = busy_q;
   assign count         = count_q;
   assign count_next    = count_d;
   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_unf_q;

endmodule

// File: rtl/occupancy_tracker.sv
// -----------------------------------------------------------------------------
// occupancy_tracker
// Multi-channel in-flight value tracker for the float pipelines. Counts values
// entering/leaving each channel, reports occupancy, busy and back-pressure,
// keeps sticky error flags and runs a drain sequencer that blocks new input
// until every channel is empty, then pulses drain_done for one cycle.
//
// Optional feature (macro OCC_TRACK_HIGHWATER_EN): adds output high_water,
// the per-channel peak occupancy since reset or the last err_clr.
//
// Ports:
//   aclk, reset      clock, synchronous active-high reset
//   sig_in/sig_out   per-channel enter/leave strobes
//   can_accept       per-channel back-pressure (0 while full or draining)
//   busy             per-channel occupancy != 0 (registered)
//   all_idle         no channel busy (registered)
//   occupancy        per-channel count, channel i at [i*CNT_W +: CNT_W]
//   err_overflow     sticky per-channel overflow
//   err_underflow    sticky per-channel underflow
//   err_clr          clears sticky flags
//   drain_req        start a drain (sampled in IDLE only)
//   draining         drain active
//   drain_done       one-cycle completion pulse
//   high_water       (optional) per-channel peak occupancy
// -----------------------------------------------------------------------------
module occupancy_tracker
   import occupancy_tracker_pkg::*;
#(
   parameter int unsigned NUM_CH          = 1,
   parameter int unsigned CNT_W           = 8,
   parameter int unsigned MAX_OUTSTANDING = 255
) (
   input  logic                    aclk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       sig_in,
   input  logic [NUM_CH-1:0]       sig_out,
   output logic [NUM_CH-1:0]       can_accept,
   output logic [NUM_CH-1:0]       busy,
   output logic                    all_idle,
   output logic [NUM_CH*CNT_W-1:0] occupancy,
   output logic [NUM_CH-1:0]       err_overflow,
   output logic [NUM_CH-1:0]       err_underflow,
   input  logic                    err_clr,
   input  logic                    drain_req,
   output logic                    draining,
   output logic                    drain_done
`ifdef OCC_TRACK_HIGHWATER_EN
   ,
   output logic [NUM_CH*CNT_W-1:0] high_water
`endif
);

   if (!max_outstanding_ok(64'(MAX_OUTSTANDING), CNT_W)) begin : g_bad_max
      $error("occupancy_tracker: MAX_OUTSTANDING must be in 1..2**CNT_W-1");
   end
   if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
      $error("occupancy_tracker: NUM_CH must be in 1..16");
   end

   drain_state_e           state_q, state_d;
   logic                   draining_s;
   logic                   drain_done_s;
   logic                   all_idle_q;
   logic                   next_all_zero_s;
   logic [NUM_CH*CNT_W-1:0] count_next_s;

   assign draining_s = (state_q == DRAIN);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam int unsigned LSB = ch_lsb(i, CNT_W);

      occupancy_counter #(
         .CNT_W           (CNT_W),
         .MAX_OUTSTANDING (MAX_OUTSTANDING)
      ) u_cnt (
         .aclk          (aclk),
         .reset         (reset),
         .sig_in        (sig_in[i]),
         .sig_out       (sig_out[i]),
         .err_clr       (err_clr),
         .draining      (draining_s),
         .can_accept    (can_accept[i]),
         .busy          (busy[i]),
         .count         (occupancy[LSB +: CNT_W]),
         .count_next    (count_next_s[LSB +: CNT_W]),
         .err_overflow  (err_overflow[i]),
         .err_underflow (err_underflow[i])
      );

`ifdef OCC_TRACK_HIGHWATER_EN
      logic [CNT_W-1:0] hw_q, hw_d;
      logic [CNT_W-1:0] nxt_s;

      assign nxt_s = count_next_s[LSB +: CNT_W];

      // Peak tracking; err_clr restarts the peak from the incoming count.
      always_comb begin
         hw_d = hw_q;
         if (err_clr) begin
            hw_d = nxt_s;
         end else if (nxt_s > hw_q) begin
            hw_d = nxt_s;
         end else begin
            hw_d = hw_q;
         end
      end

      // High-water register.
      always_ff @(posedge aclk) begin
         if (reset) begin
            hw_q <= '0;
         end else begin
            hw_q <= hw_d;
         end
      end

      assign high_water[LSB +: CNT_W] = hw_q;
`endif
   end

   // all_idle and the drain exit look at the next counts so they line up with busy.
   assign next_all_zero_s = (count_next_s == '0);

   // Drain FSM next state and decoded outputs.
   always_comb begin
      state_d      = state_q;
      drain_done_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (drain_req) begin
               state_d = DRAIN;
            end else begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (next_all_zero_s) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            drain_done_s = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Drain state and all_idle registers.
   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q    <= IDLE;
         all_idle_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         all_idle_q <= next_all_zero_s;
      end
   end

   assign draining   = draining_s;
   assign drain_done = drain_done_s;
   assign all_idle   = all_idle_q;

endmodule

// File: tb/tb_occupancy_tracker.sv
// -----------------------------------------------------------------------------
// tb_occupancy_tracker
// Directed self-checking bench. Two instances share one clock:
//   u_a : NUM_CH=1, CNT_W=8, MAX_OUTSTANDING=255 (basic counting, underflow)
//   u_b : NUM_CH=2, CNT_W=8, MAX_OUTSTANDING=4   (overflow, drain sequences)
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_occupancy_tracker;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic       reset;
   logic       err_clr;

   logic       a_in, a_out, a_can, a_busy, a_idle, a_ovf, a_unf, a_dreq, a_drn, a_done;
   logic [7:0] a_occ;

   logic [1:0]  b_in, b_out, b_can, b_busy, b_ovf, b_unf;
   logic        b_idle, b_dreq, b_drn, b_done;
   logic [15:0] b_occ;
`ifdef OCC_TRACK_HIGHWATER_EN
   logic [7:0]  a_hw;
   logic [15:0] b_hw;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   occupancy_tracker #(.NUM_CH(1), .CNT_W(8), .MAX_OUTSTANDING(255)) u_a (
      .aclk          (aclk),
      .reset         (reset),
      .sig_in        (a_in),
      .sig_out       (a_out),
      .can_accept    (a_can),
      .busy          (a_busy),
      .all_idle      (a_idle),
      .occupancy     (a_occ),
      .err_overflow  (a_ovf),
      .err_underflow (a_unf),
      .err_clr       (err_clr),
      .drain_req     (a_dreq),
      .draining      (a_drn),
      .drain_done    (a_done)
`ifdef OCC_TRACK_HIGHWATER_EN
      ,
      .high_water    (a_hw)
`endif
   );

   occupancy_tracker #(.NUM_CH(2), .CNT_W(8), .MAX_OUTSTANDING(4)) u_b (
      .aclk          (aclk),
      .reset         (reset),
      .sig_in        (b_in),
      .sig_out       (b_out),
      .can_accept    (b_can),
      .busy          (b_busy),
      .all_idle      (b_idle),
      .occupancy     (b_occ),
      .err_overflow  (b_ovf),
      .err_underflow (b_unf),
      .err_clr       (err_clr),
      .drain_req     (b_dreq),
      .draining      (b_drn),
      .drain_done    (b_done)
`ifdef OCC_TRACK_HIGHWATER_EN
      ,
      .high_water    (b_hw)
`endif
   );

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; err_clr = 1'b0;
      a_in = 1'b0; a_out = 1'b0; a_dreq = 1'b0;
      b_in = 2'b00; b_out = 2'b00; b_dreq = 1'b0;
      tick();
      tick();
      // Reset state
      chk("rst_a_occ",   64'(a_occ),  64'd0);
      chk("rst_a_busy",  64'(a_busy), 64'd0);
      chk("rst_a_idle",  64'(a_idle), 64'd1);
      chk("rst_a_can",   64'(a_can),  64'd1);
      chk("rst_b_occ",   64'(b_occ),  64'd0);
      chk("rst_b_err",   64'({b_ovf, b_unf}), 64'd0);
      chk("rst_b_drain", 64'({b_drn, b_done}), 64'd0);
      chk("rst_b_can",   64'(b_can),  64'd3);
      reset = 1'b0;

      // Three increments then three decrements on u_a
      for (int k = 1; k <= 3; k++) begin
         a_in = 1'b1;
         tick();
         chk("inc_occ",  64'(a_occ),  64'(k));
         chk("inc_busy", 64'(a_busy), 64'd1);
         chk("inc_idle", 64'(a_idle), 64'd0);
      end
      a_in = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         a_out = 1'b1;
         tick();
         chk("dec_occ",  64'(a_occ),  64'(3 - k));
         chk("dec_busy", 64'(a_busy), (k == 3) ? 64'd0 : 64'd1);
         chk("dec_idle", 64'(a_idle), (k == 3) ? 64'd1 : 64'd0);
      end

      // Simultaneous in/out at count 0
      a_in = 1'b1; a_out = 1'b1;
      tick();
      chk("sim0_occ",  64'(a_occ),  64'd0);
      chk("sim0_busy", 64'(a_busy), 64'd0);
      chk("sim0_err",  64'({a_ovf, a_unf}), 64'd0);

      // Bring to 5, then simultaneous in/out
      a_out = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("fill5_occ", 64'(a_occ), 64'd5);
      a_out = 1'b1;
      tick();
      chk("sim5_occ",  64'(a_occ),  64'd5);
      chk("sim5_busy", 64'(a_busy), 64'd1);
      chk("sim5_err",  64'({a_ovf, a_unf}), 64'd0);
      a_in = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("empty_occ", 64'(a_occ), 64'd0);

      // Underflow at count 0
      tick();
      chk("unf_occ",  64'(a_occ), 64'd0);
      chk("unf_flag", 64'(a_unf), 64'd1);
      chk("unf_ovf",  64'(a_ovf), 64'd0);
      a_out = 1'b0;
      tick();
      chk("unf_sticky", 64'(a_unf), 64'd1);
      err_clr = 1'b1;
      tick();
      chk("unf_clr", 64'(a_unf), 64'd0);
      err_clr = 1'b0;

      // Overflow on u_b channel 0 (limit 4)
      b_in = 2'b01;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("ovf_fill_occ", 64'(b_occ), 64'(k));
         chk("ovf_fill_can", 64'(b_can), (k < 4) ? 64'd3 : 64'd2);
      end
      chk("ovf_pre_flag", 64'(b_ovf), 64'd0);
      tick();
      chk("ovf_occ",  64'(b_occ), 64'd4);
      chk("ovf_flag", 64'(b_ovf), 64'd1);
      b_in = 2'b00;
      tick();
      chk("ovf_sticky", 64'(b_ovf), 64'd1);
      err_clr = 1'b1;
      tick();
      chk("ovf_clr", 64'(b_ovf), 64'd0);
      b_in = 2'b01;
      tick();
      chk("ovf_clr_and_new", 64'(b_ovf), 64'd1);
      b_in = 2'b00;
      tick();
      chk("ovf_clr2", 64'(b_ovf), 64'd0);
      err_clr = 1'b0;

      // Set up counts ch0=2, ch1=1
      b_out = 2'b01;
      tick();
      tick();
      b_out = 2'b00; b_in = 2'b10;
      tick();
      b_in = 2'b00;
      chk("pre_drain_occ", 64'(b_occ), 64'h0102);

      // Drain with a one-cycle request
      b_dreq = 1'b1;
      tick();
      b_dreq = 1'b0;
      chk("drn_active", 64'(b_drn),  64'd1);
      chk("drn_can",    64'(b_can),  64'd0);
      chk("drn_done0",  64'(b_done), 64'd0);
      b_out = 2'b10;
      tick();
      chk("drn_occ1", 64'(b_occ), 64'h0002);
      chk("drn_act1", 64'(b_drn), 64'd1);
      b_out = 2'b01;
      tick();
      chk("drn_occ2",  64'(b_occ),  64'h0001);
      chk("drn_done2", 64'(b_done), 64'd0);
      tick();
      b_out = 2'b00;
      chk("drn_occ3",  64'(b_occ),  64'h0000);
      chk("drn_done3", 64'(b_done), 64'd1);
      chk("drn_act3",  64'(b_drn),  64'd0);
      chk("drn_idle3", 64'(b_idle), 64'd1);
      tick();
      chk("drn_done4", 64'(b_done), 64'd0);
      chk("drn_can4",  64'(b_can),  64'd3);
      chk("drn_err4",  64'({b_ovf, b_unf}), 64'd0);

      // Reset mid-drain
      b_in = 2'b01;
      tick();
      b_in = 2'b00; b_dreq = 1'b1;
      tick();
      b_dreq = 1'b0;
      chk("abort_act", 64'(b_drn), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_drn",  64'(b_drn),  64'd0);
      chk("abort_done", 64'(b_done), 64'd0);
      chk("abort_occ",  64'(b_occ),  64'd0);
      tick();
      chk("abort_done2", 64'(b_done), 64'd0);

      // Drain request while idle: done two cycles after the request
      b_dreq = 1'b1;
      tick();
      b_dreq = 1'b0;
      chk("idle_drn_act",  64'(b_drn),  64'd1);
      chk("idle_drn_done", 64'(b_done), 64'd0);
      tick();
      chk("idle_drn_done2", 64'(b_done), 64'd1);
      tick();
      chk("idle_drn_done3", 64'(b_done), 64'd0);

`ifdef OCC_TRACK_HIGHWATER_EN
      b_in = 2'b01;
      tick(); tick(); tick();
      b_in = 2'b00; b_out = 2'b01;
      tick();
      b_out = 2'b00;
      chk("hw_occ",  64'(b_occ), 64'h0002);
      chk("hw_peak", 64'(b_hw),  64'h0003);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("hw_clr", 64'(b_hw), 64'h0002);
      b_out = 2'b01;
      tick();
      b_out = 2'b00;
      chk("hw_hold", 64'(b_hw), 64'h0002);
      chk("hw_a",    64'(a_hw), 64'h0000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/occupancy_tracker.md
Name: occupancy_tracker

Overview:
- Parametrised multi-channel in-flight value tracker for the float pipelines.
- Counts values entering and leaving each of NUM_CH pipelines and reports per-channel occupancy, busy and back-pressure.
- Adds sticky over/underflow errors and a drain sequencer that blocks new input until all channels are empty, then pulses done.
- Sits beside the arithmetic pipelines and feeds the control logic that must know when the datapath is empty.

Parameters:
- NUM_CH, 1, number of independently tracked channels (1..16).
- CNT_W, 8, per-channel counter width in bits.
- MAX_OUTSTANDING, 255, per-channel occupancy limit; must satisfy 1 <= MAX_OUTSTANDING <= 2**CNT_W-1.

Ports:
- aclk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- sig_in  in  NUM_CH  bit i = one value enters channel i this cycle.
- sig_out  in  NUM_CH  bit i = one value leaves channel i this cycle.
- can_accept  out  NUM_CH  bit i = channel i may take a new value this cycle.
- busy  out  NUM_CH  bit i = channel i holds at least one value.
- all_idle  out  1  no channel busy.
- occupancy  out  NUM_CH*CNT_W  per-channel count; channel i at bits [i*CNT_W +: CNT_W].
- err_overflow  out  NUM_CH  sticky overflow flag per channel.
- err_underflow  out  NUM_CH  sticky underflow flag per channel.
- err_clr  in  1  clears all sticky error flags.
- drain_req  in  1  request a drain (level or pulse; sampled only in IDLE).
- draining  out  1  drain sequence active.
- drain_done  out  1  one-cycle pulse when the drain completes.

Behaviour:
- Interface: one clock, aclk. Reset is synchronous and active-high on port reset. Everything is sampled on the posedge of aclk.
- Reset values:
  - occupancy = 0, busy = 0, all_idle = 1.
  - Both error vectors = 0.
  - draining = 0, drain_done = 0.
  - FSM in IDLE.
- Counter update per channel, next = count + sig_in - sig_out:
  - in=1, out=1: count unchanged.
  - in=1, out=0: increment.
  - in=0, out=1: decrement.
  - in=0, out=0: hold.
- Overflow: in=1, out=0 with count == MAX_OUTSTANDING.
  - Count holds (saturates).
  - err_overflow[i] is set.
- Underflow: in=0, out=1 with count == 0.
  - Count stays 0.
  - err_underflow[i] is set.
- Error flag priority: error flags stay set until err_clr. If err_clr and a new error occur in the same cycle, the flag stays set.
- busy and occupancy timing:
  - busy[i] is registered as (next != 0), so it updates in the same cycle as occupancy, one cycle after the event.
  - Simultaneous in/out while count == 0 leaves busy = 0.
- all_idle: registered, equals NOR of next busy.
- can_accept[i]: combinational from registered state only (no path from sig_in or sig_out) = (count < MAX_OUTSTANDING) AND NOT draining.
- Drain FSM states IDLE, DRAIN, DONE:
  - IDLE -> DRAIN when drain_req = 1.
  - DRAIN: draining = 1, which forces can_accept = 0. Counting continues, including any sig_in that violates the gate; such a value is counted normally and no error is raised.
  - DRAIN -> DONE in the cycle where all next counts are 0.
  - DONE: drain_done = 1 for exactly one cycle, draining = 0. Always returns to IDLE next cycle.
  - drain_req in DRAIN or DONE is ignored.
  - A drain request while already idle reaches DONE on the next cycle, so drain_done goes high 2 cycles after drain_req.
- Reset mid-drain returns to IDLE immediately. No drain_done pulse is issued.
- Counter arithmetic is done in CNT_W bits with the saturation above. Unsigned wrap-around never occurs.

Optional Feature:
- Macro: OCC_TRACK_HIGHWATER_EN.
- Defined:
  - Adds output port high_water (NUM_CH*CNT_W): per-channel peak occupancy since reset or the last err_clr.
  - Each peak updates registered as max(peak, next).
  - err_clr loads the current next count.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Decomposition:
- Package occupancy_tracker_pkg holds:
  - the drain FSM state enum (IDLE, DRAIN, DONE);
  - a function returning the bit slice of channel i;
  - an elaboration-time parameter check that MAX_OUTSTANDING fits in CNT_W.
- Sub-module occupancy_counter: one channel's saturating counter, busy and error flags. It is instantiated NUM_CH times in a generate loop.
- The top level holds the drain FSM, the all_idle reduction and the optional high-water logic.

Test Plan:
- NUM_CH=1: 3 cycles sig_in=1, then 3 cycles sig_out=1.
  - occupancy is 1,2,3 then 2,1,0, each one cycle after its event.
  - busy falls in the same cycle occupancy reaches 0.
  - all_idle rises in the same cycle busy falls.
- Simultaneous sig_in=sig_out=1 at count 0 and at count 5 -> counts stay 0 and 5; busy stays 0 and 1 respectively; no errors.
- MAX_OUTSTANDING=4: 5 increments.
  - can_accept goes 0 after the 4th increment.
  - The 5th increment sets err_overflow and occupancy stays 4.
  - err_clr clears the flag.
  - err_clr together with a new overflow leaves the flag at 1.
- Count 0 plus sig_out=1 -> err_underflow=1, occupancy stays 0.
- NUM_CH=2 drain with counts 2 and 1, drain_req pulse:
  - draining=1 and both can_accept bits = 0.
  - Three sig_out events, last on channel 0 -> drain_done pulses one cycle after the last decrement, then IDLE.
- Drain abort and idle drain:
  - Assert reset while draining -> next cycle draining=0, drain_done stays 0, all counters 0.
  - drain_req while idle -> drain_done pulses 2 cycles later.
  - With OCC_TRACK_HIGHWATER_EN defined: high_water equals the peak count, then tracks the current count after err_clr.
